// File: rtl/rom_port_responder.sv
// ROM-side responder for the 4-bit multiplexed CPU bus: follows the 8-phase
// instruction cycle, returns instruction bytes on a chip-ID hit and serves a 4-bit I/O port.
module rom_port_responder #(
    parameter logic [3:0] CHIP_ID = 4'h0
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       halt,
    input  logic       sync,
    input  logic [3:0] data_i,
    input  logic       rom_cmd,
    output logic [3:0] data_o,
    output logic       data_en,
    output logic [7:0] mem_addr,
    input  logic [7:0] mem_data,
    input  logic [3:0] io_in,
    output logic [3:0] io_out
);

    typedef enum logic [2:0] {
        PH_A1, PH_A2, PH_A3, PH_M1, PH_M2, PH_X1, PH_X2, PH_X3
    } phase_t;

    phase_t      r_phase;
    phase_t      w_phase_next;
    logic        r_synced;
    logic        w_synced_next;
    logic        r_chip_hit;
    logic        r_io_cmd;
    logic        r_selected;
    logic [7:0]  r_opcode;
    logic [7:0]  r_mem_addr;
    logic [3:0]  r_io_out;
    logic        w_wrr;
    logic        w_rdr;

    assign w_wrr = r_io_cmd && r_selected && (r_opcode == 8'hE2);
    assign w_rdr = r_io_cmd && r_selected && (r_opcode == 8'hEA);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_phase  <= PH_A1;
            r_synced <= 1'b0;
        end else begin
            r_phase  <= w_phase_next;
            r_synced <= w_synced_next;
        end
    end

    // A sync in any phase restarts the cycle at A1; the current phase still completes.
    always_comb begin
        w_phase_next  = r_phase;
        w_synced_next = r_synced;
        if (!halt) begin
            if (sync) begin
                w_synced_next = 1'b1;
                w_phase_next  = PH_A1;
            end else if (r_synced) begin
                w_phase_next = phase_t'(r_phase + 3'd1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_chip_hit <= 1'b0;
            r_io_cmd   <= 1'b0;
            r_selected <= 1'b0;
            r_opcode   <= 8'h00;
            r_mem_addr <= 8'h00;
            r_io_out   <= 4'h0;
        end else if (!halt && r_synced) begin
            case (r_phase)
                PH_A1: r_mem_addr[3:0] <= data_i;
                PH_A2: r_mem_addr[7:4] <= data_i;
                PH_A3: r_chip_hit      <= (data_i == CHIP_ID);
                PH_M1: r_opcode[7:4]   <= data_i;
                PH_M2: begin
                    r_opcode[3:0] <= data_i;
                    r_io_cmd      <= rom_cmd;
                end
                PH_X2: begin
                    if (rom_cmd && !r_io_cmd)
                        r_selected <= (data_i == CHIP_ID);
                    if (w_wrr)
                        r_io_out <= data_i;
                end
                default: ;
            endcase
        end
    end

    // Bus drive is decoded from the current phase so it appears with no added latency.
    always_comb begin
        data_en = 1'b0;
        data_o  = 4'h0;
        if (r_synced) begin
            case (r_phase)
                PH_M1: if (r_chip_hit) begin
                    data_en = 1'b1;
                    data_o  = mem_data[7:4];
                end
                PH_M2: if (r_chip_hit) begin
                    data_en = 1'b1;
                    data_o  = mem_data[3:0];
                end
                PH_X2: if (w_rdr) begin
                    data_en = 1'b1;
                    data_o  = io_in;
                end
                default: ;
            endcase
        end
    end

    assign mem_addr = r_mem_addr;
    assign io_out   = r_io_out;

endmodule

// File: tb/tb_rom_port_responder.sv
// Randomized and directed bench for rom_port_responder against a cycle-level
// behavioural model of the instruction-cycle rules.
module tb_rom_port_responder;

    localparam logic [3:0] CHIP = 4'h0;

    logic       clock;
    logic       reset;
    logic       halt;
    logic       sync;
    logic [3:0] data_i;
    logic       rom_cmd;
    logic [3:0] data_o;
    logic       data_en;
    logic [7:0] mem_addr;
    logic [7:0] mem_data;
    logic [3:0] io_in;
    logic [3:0] io_out;

    logic [3:0] bus_drv;
    logic [7:0] rom [256];

    int n_checks = 0;
    int n_err    = 0;
    bit chk_on   = 0;

    // Resolved bus: the responder wins when it drives, otherwise the bench driver.
    assign data_i   = data_en ? data_o : bus_drv;
    assign mem_data = rom[mem_addr];

    rom_port_responder #(.CHIP_ID(CHIP)) dut (
        .clock   (clock),
        .reset   (reset),
        .halt    (halt),
        .sync    (sync),
        .data_i  (data_i),
        .rom_cmd (rom_cmd),
        .data_o  (data_o),
        .data_en (data_en),
        .mem_addr(mem_addr),
        .mem_data(mem_data),
        .io_in   (io_in),
        .io_out  (io_out)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Behavioural model: phase index 0..7 = A1,A2,A3,M1,M2,X1,X2,X3
    bit         m_synced = 0;
    logic [2:0] m_ph     = 3'd0;
    bit         m_hit    = 0;
    bit         m_iocmd  = 0;
    bit         m_sel    = 0;
    logic [7:0] m_addr   = 8'h00;
    logic [7:0] m_op     = 8'h00;
    logic [3:0] m_io     = 4'h0;

    function automatic void exp_out(output logic en, output logic [3:0] o);
        logic [7:0] byte_v;
        en = 1'b0;
        o  = 4'h0;
        byte_v = rom[m_addr];
        if (m_synced) begin
            if (m_ph == 3'd3 && m_hit) begin
                en = 1'b1; o = byte_v[7:4];
            end else if (m_ph == 3'd4 && m_hit) begin
                en = 1'b1; o = byte_v[3:0];
            end else if (m_ph == 3'd6 && m_iocmd && m_sel && m_op == 8'hEA) begin
                en = 1'b1; o = io_in;
            end
        end
    endfunction

    task automatic model_step();
        logic       e_en;
        logic [3:0] e_o;
        logic [3:0] bus;
        exp_out(e_en, e_o);
        bus = e_en ? e_o : bus_drv;
        if (reset) begin
            m_synced = 0; m_ph = 3'd0; m_hit = 0; m_iocmd = 0; m_sel = 0;
            m_addr = 8'h00; m_op = 8'h00; m_io = 4'h0;
        end else if (!halt) begin
            if (m_synced) begin
                case (m_ph)
                    3'd0: m_addr[3:0] = bus;
                    3'd1: m_addr[7:4] = bus;
                    3'd2: m_hit = (bus == CHIP);
                    3'd3: m_op[7:4] = bus;
                    3'd4: begin m_op[3:0] = bus; m_iocmd = rom_cmd; end
                    3'd6: begin
                        if (m_iocmd && m_sel && m_op == 8'hE2) m_io = bus;
                        if (rom_cmd && !m_iocmd) m_sel = (bus == CHIP);
                    end
                    default: ;
                endcase
            end
            if (sync) begin
                m_synced = 1; m_ph = 3'd0;
            end else if (m_synced) begin
                m_ph = m_ph + 3'd1;
            end
        end
    endtask

    initial forever begin
        @(posedge clock);
        model_step();
    end

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Single per-cycle compare against the model, away from the active edge.
    initial forever begin
        logic       e_en;
        logic [3:0] e_o;
        @(negedge clock);
        if (chk_on) begin
            exp_out(e_en, e_o);
            chk("cyc_data_en", {7'b0, data_en}, {7'b0, e_en});
            chk("cyc_data_o", {4'b0, data_o}, {4'b0, e_o});
            chk("cyc_mem_addr", mem_addr, m_addr);
            chk("cyc_io_out", {4'b0, io_out}, {4'b0, m_io});
        end
    end

    logic       s_en;
    logic [3:0] s_o;
    logic [3:0] io_val;
    logic       obs_en [8];
    logic [3:0] obs_o  [8];

    task automatic ph(input logic s, input logic [3:0] b, input logic rc,
                      input logic h, input logic r);
        @(posedge clock);
        #1;
        sync = s; bus_drv = b; rom_cmd = rc; halt = h; reset = r; io_in = io_val;
        @(negedge clock);
        s_en = data_en;
        s_o  = data_o;
    endtask

    task automatic run_instr(input string nm, input logic [3:0] a0, input logic [3:0] a1,
                             input logic [3:0] a2, input logic [3:0] o1, input logic [3:0] o0,
                             input logic rc_m2, input logic rc_x2, input logic [3:0] x2b,
                             input int hold, input logic [3:0] hold_o);
        ph(0, a0, 0, 0, 0); obs_en[0] = s_en; obs_o[0] = s_o;
        ph(0, a1, 0, 0, 0); obs_en[1] = s_en; obs_o[1] = s_o;
        ph(0, a2, 0, 0, 0); obs_en[2] = s_en; obs_o[2] = s_o;
        ph(0, o1, 0, (hold > 0), 0); obs_en[3] = s_en; obs_o[3] = s_o;
        for (int k = 0; k < hold; k++) begin
            ph(0, o1, 0, (k < hold - 1), 0);
            chk("halt_m1_en", {7'b0, s_en}, 8'h01);
            chk("halt_m1_o", {4'b0, s_o}, {4'b0, hold_o});
        end
        ph(0, o0, rc_m2, 0, 0); obs_en[4] = s_en; obs_o[4] = s_o;
        ph(0, 4'h0, 0, 0, 0);   obs_en[5] = s_en; obs_o[5] = s_o;
        ph(0, x2b, rc_x2, 0, 0); obs_en[6] = s_en; obs_o[6] = s_o;
        ph(1, 4'h0, 0, 0, 0);   obs_en[7] = s_en; obs_o[7] = s_o;
        $display("instr %-10s addr=%h opcode_bus=%h%h en=%b%b%b%b%b%b%b%b io_out=%h",
                 nm, mem_addr, o1, o0, obs_en[0], obs_en[1], obs_en[2], obs_en[3],
                 obs_en[4], obs_en[5], obs_en[6], obs_en[7], io_out);
    endtask

    initial begin
        int pos;
        logic s, h, r, rc;
        logic [3:0] b;
        for (int i = 0; i < 256; i++) rom[i] = 8'($urandom);
        rom[8'h12] = 8'hA5;
        reset = 1; halt = 0; sync = 0; rom_cmd = 0; bus_drv = 0; io_in = 0; io_val = 0;

        ph(0, 4'h0, 0, 0, 1);
        chk_on = 1;
        ph(0, 4'h0, 0, 0, 1);
        chk("reset_data_en", {7'b0, data_en}, 8'h00);
        chk("reset_mem_addr", mem_addr, 8'h00);
        chk("reset_io_out", {4'b0, io_out}, 8'h00);

        ph(1, 4'h0, 0, 0, 0);  // first sync, acts as X3
        run_instr("fetch_hit", 4'h2, 4'h1, 4'h0, 4'h0, 4'h0, 0, 0, 4'h0, 0, 4'h0);
        chk("hit_mem_addr", mem_addr, 8'h12);
        chk("hit_m1_en", {7'b0, obs_en[3]}, 8'h01);
        chk("hit_m1_o", {4'b0, obs_o[3]}, 8'h0A);
        chk("hit_m2_en", {7'b0, obs_en[4]}, 8'h01);
        chk("hit_m2_o", {4'b0, obs_o[4]}, 8'h05);
        for (int p = 0; p < 8; p++)
            if (p != 3 && p != 4) chk("hit_other_en", {7'b0, obs_en[p]}, 8'h00);

        run_instr("fetch_miss", 4'h2, 4'h1, 4'h3, 4'h4, 4'h7, 0, 0, 4'h0, 0, 4'h0);
        for (int p = 0; p < 8; p++) chk("miss_en", {7'b0, obs_en[p]}, 8'h00);

        run_instr("src0", 4'h0, 4'h0, 4'h3, 4'h2, 4'h1, 0, 1, 4'h0, 0, 4'h0);
        run_instr("wrr7", 4'h0, 4'h0, 4'h3, 4'hE, 4'h2, 1, 0, 4'h7, 0, 4'h0);
        chk("wrr_io_out", {4'b0, io_out}, 8'h07);
        run_instr("src1", 4'h0, 4'h0, 4'h3, 4'h2, 4'h1, 0, 1, 4'h1, 0, 4'h0);
        run_instr("wrr9", 4'h0, 4'h0, 4'h3, 4'hE, 4'h2, 1, 0, 4'h9, 0, 4'h0);
        chk("wrr_unsel_io_out", {4'b0, io_out}, 8'h07);

        run_instr("src0", 4'h0, 4'h0, 4'h3, 4'h2, 4'h1, 0, 1, 4'h0, 0, 4'h0);
        io_val = 4'hC;
        run_instr("rdr", 4'h0, 4'h0, 4'h3, 4'hE, 4'hA, 1, 0, 4'h0, 0, 4'h0);
        chk("rdr_x2_en", {7'b0, obs_en[6]}, 8'h01);
        chk("rdr_x2_o", {4'b0, obs_o[6]}, 8'h0C);
        chk("rdr_x1_en", {7'b0, obs_en[5]}, 8'h00);
        chk("rdr_x3_en", {7'b0, obs_en[7]}, 8'h00);

        run_instr("halt_hit", 4'h2, 4'h1, 4'h0, 4'h0, 4'h0, 0, 0, 4'h0, 3, 4'hA);
        chk("halt_m2_en", {7'b0, obs_en[4]}, 8'h01);
        chk("halt_m2_o", {4'b0, obs_o[4]}, 8'h05);

        ph(0, 4'h4, 0, 0, 0);
        ph(0, 4'h5, 0, 0, 0);
        ph(1, 4'h0, 0, 0, 0);  // stray sync at A3
        chk("stray_addr", mem_addr, 8'h54);
        run_instr("resync_hit", 4'h2, 4'h1, 4'h0, 4'h0, 4'h0, 0, 0, 4'h0, 0, 4'h0);
        chk("resync_m1_o", {4'b0, obs_o[3]}, 8'h0A);
        chk("resync_m2_en", {7'b0, obs_en[4]}, 8'h01);

        ph(0, 4'h2, 0, 0, 0);
        ph(0, 4'h1, 0, 0, 0);
        ph(0, 4'h0, 0, 0, 0);
        ph(0, 4'h0, 0, 0, 0);
        ph(0, 4'h0, 0, 0, 1);  // reset during M2 of a hit
        ph(0, 4'h0, 0, 0, 0);
        chk("rst_mid_en", {7'b0, s_en}, 8'h00);
        chk("rst_mid_io_out", {4'b0, io_out}, 8'h00);
        for (int k = 0; k < 10; k++) begin
            ph(0, 4'($urandom), 1'($urandom), 0, 0);
            chk("rst_nodrive_en", {7'b0, s_en}, 8'h00);
        end
        ph(1, 4'h0, 0, 0, 0);
        run_instr("wrr_nosel", 4'h0, 4'h0, 4'h3, 4'hE, 4'h2, 1, 0, 4'h5, 0, 4'h0);
        chk("rst_sel_cleared", {4'b0, io_out}, 8'h00);

        pos = 7;
        for (int c = 0; c < 4000; c++) begin
            io_val = 4'($urandom);
            b  = 4'($urandom);
            if (pos == 2 && $urandom_range(1) == 1) b = CHIP;
            if (pos == 3 && $urandom_range(1) == 1) b = 4'hE;
            if (pos == 4 && $urandom_range(1) == 1) b = ($urandom_range(1) == 1) ? 4'h2 : 4'hA;
            if (pos == 6 && $urandom_range(2) == 0) b = CHIP;
            s  = (pos == 7) || ($urandom_range(59) == 0);
            h  = ($urandom_range(9) == 0);
            r  = ($urandom_range(299) == 0);
            rc = 1'($urandom);
            ph(s, b, rc, h, r);
            if (!h) pos = s ? 0 : (pos + 1) % 8;
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
